// File: rtl/mem_wb_unit.sv
// Memory/writeback stage: latches execute results, runs the data-memory
// req/ack access with timeout abort, and returns the register-file write.
module mem_wb_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_reg_write,
  input  logic              ex_mem_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_to_reg,
  input  logic [4:0]        ex_dest_reg,
  input  logic [DATA_W-1:0] ex_out,
  input  logic [DATA_W-1:0] ex_mem_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic              wb_reg_write,
  output logic [4:0]        wb_dest_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              mem_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic              reg_write;
    logic              mem_write;
    logic              mem_read;
    logic              mem_to_reg;
    logic [4:0]        dest_reg;
    logic [DATA_W-1:0] out;
  } m_t;

  state_t           state, state_nxt;
  m_t               m_q;
  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic             ex_memop;
  logic             m_load;
  logic             timeout_hit;
  logic             done;
  logic             launch;

  assign busy        = (state == BUSY);
  assign ex_memop    = ex_mem_read | ex_mem_write;
  assign m_load      = m_q.mem_read & ~m_q.mem_write;
  assign timeout_hit = busy & ~mem_ack
                     & (cnt == CNT_W'(TIMEOUT - 1));
  assign stall       = busy & ~mem_ack & ~timeout_hit;
  // In IDLE the latched instruction is never a memop, so it completes.
  assign done        = ~stall;
  assign launch      = ~stall & ex_memop;
  assign mem_req     = busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (launch) state_nxt = BUSY;
      BUSY: if (!stall) state_nxt = launch ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q <= '0;
    end else if (!stall) begin
      m_q.reg_write  <= ex_reg_write;
      m_q.mem_write  <= ex_mem_write;
      m_q.mem_read   <= ex_mem_read;
      m_q.mem_to_reg <= ex_mem_to_reg;
      m_q.dest_reg   <= ex_dest_reg;
      m_q.out        <= ex_out;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if (launch) cnt <= '0;
      else if (stall) cnt <= cnt + 1'b1;
      // Request fields are held outside BUSY.
      if (launch) begin
        mem_we    <= ex_mem_write;
        mem_addr  <= ex_out[ADDR_W-1:0];
        mem_wdata <= ex_mem_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_reg_write <= 1'b0;
      wb_dest_reg  <= '0;
      wb_data      <= '0;
      mem_err      <= 1'b0;
    end else begin
      wb_reg_write <= done & m_q.reg_write & ~timeout_hit;
      if (done) begin
        wb_dest_reg <= m_q.dest_reg;
        wb_data     <= (busy & m_load & m_q.mem_to_reg)
                     ? mem_rdata : m_q.out;
      end
      if (timeout_hit) mem_err <= 1'b1;
    end
  end

endmodule

// File: doc/mem_wb_unit.md
Name: mem_wb_unit

Overview:
- Memory/writeback stage of the Tronsistor pipeline; the consumer end of the execute-stage outputs.
- Latches execute-stage results and performs the data-memory access over a req/ack handshake.
- Returns the register-file write (enable, register, data) to the decode stage.
- Stalls upstream while a memory access is outstanding; aborts hung accesses via a timeout.

Parameters:
- DATA_W, 32, data path width
- ADDR_W, 16, memory address width (low bits of ex_out)
- TIMEOUT, 255, max cycles waiting for mem_ack before abort (1..2^CNT_W-1)
- CNT_W, 8, timeout counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- ex_reg_write  in  1  execute stage: instruction writes a register
- ex_mem_write  in  1  execute stage: store
- ex_mem_read  in  1  execute stage: load
- ex_mem_to_reg  in  1  writeback data source: 1 = memory read data, 0 = ex_out
- ex_dest_reg  in  5  destination register
- ex_out  in  DATA_W  ALU result / memory address
- ex_mem_wdata  in  DATA_W  store data
- mem_req  out  1  memory request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid when mem_ack=1
- mem_ack  in  1  memory completion, single-cycle pulse
- stall  out  1  upstream must hold its state this cycle
- wb_reg_write  out  1  register-file write enable
- wb_dest_reg  out  5  register-file write address
- wb_data  out  DATA_W  register-file write data
- mem_err  out  1  sticky flag: memory timeout occurred

Behaviour:
- Reset (rst=0, async): every register and output is 0.
  - M-stage registers cleared; state IDLE; counter 0.
  - mem_req, mem_we, mem_addr, mem_wdata, stall, wb_* and mem_err all 0.
- M-stage latch: on every rising edge with stall=0, capture all ex_* inputs into the M registers.
- Memory-op definition: memop = ex_mem_read | ex_mem_write.
  - When both are 1, the store wins: write performed, read ignored, and no memory data is written back.
- FSM, two states:
  - IDLE: at an edge with stall=0 and memop=1 on the inputs, go to BUSY and clear the counter. Otherwise stay in IDLE.
  - BUSY: mem_req=1; mem_we = latched mem_write; mem_addr = latched ex_out[ADDR_W-1:0]; mem_wdata = latched store data. These stay stable for the whole BUSY period.
  - BUSY, mem_ack=1: access completes. A load captures mem_rdata. Next state is IDLE, unless a new memop is latched at the same edge, in which case stay in BUSY, clear the counter, and drive the new request. Back-to-back requests therefore need no idle gap.
  - BUSY, mem_ack=0: counter increments. When the counter reaches TIMEOUT-1 with no ack, abort: go to IDLE, set mem_err=1, and suppress the writeback for that instruction.
- mem_req=0 in IDLE; mem_we, mem_addr and mem_wdata are don't-care in IDLE and are held at their last values.
- stall = (state==BUSY) & ~mem_ack & ~timeout_hit. This is combinational, so the ack cycle and the abort cycle do not stall.
- Writeback register:
  - At an edge where the M instruction completes, load the wb_* registers:
    - wb_reg_write = latched reg_write (forced 0 on abort).
    - wb_dest_reg = latched dest_reg.
    - wb_data = mem_rdata when mem_to_reg=1 and the op is a load; otherwise latched ex_out.
  - "Completes" means: non-memop in IDLE, or ack, or abort.
  - At every other edge, wb_reg_write is cleared to 0. Writeback is a single-cycle pulse; wb_dest_reg and wb_data hold their values.
- Latency:
  - Non-memop: ex_* sampled at edge N; wb_* valid after edge N+1.
  - Memop: mem_req is high from edge N; ack in cycle N+k (k>=0); wb_* valid after the edge that ends cycle N+k.
- mem_ack in IDLE: ignored.
- mem_err: cleared only by reset.
- Reset mid-access: the request is dropped immediately (mem_req→0 asynchronously) and no writeback occurs.

Test Plan:
- ALU op: ex_reg_write=1, dest=5, ex_out=0x1234, mem_to_reg=0 -> after 2 edges, wb_reg_write=1 for exactly 1 cycle, wb_dest_reg=5, wb_data=0x1234; stall stays 0.
- Load with 3-cycle ack delay: mem_read=1, mem_to_reg=1, dest=7, ex_out=0x0040 -> mem_req=1, mem_we=0, mem_addr=0x0040 for 3 cycles; stall=1 for 2 cycles and 0 on the ack cycle; mem_rdata=0xCAFEF00D at ack -> wb_data=0xCAFEF00D, wb_dest_reg=7.
- Store, ack same cycle: mem_write=1, ex_out=0x0100, wdata=0xDEADBEEF, reg_write=0 -> mem_req=1 with mem_we=1 and correct addr/data for 1 cycle; stall=0 throughout; wb_reg_write stays 0.
- Back-to-back loads, each acked in its first BUSY cycle -> mem_req stays high 2 consecutive cycles with addr A then B; two wb pulses on consecutive cycles with the correct data.
- Timeout, TIMEOUT=4, never ack a load -> mem_req high 4 cycles then drops; mem_err=1 and stays 1; no wb pulse; stall released; the next ALU op writes back normally.
- Assert rst=0 while BUSY -> mem_req, stall and wb_reg_write go to 0 without waiting for a clock edge; after rst release, no stale writeback appears.
